// File: rtl/bcd2binary_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Define BCD2BIN_CHECK_EN to add the err output flagging digits above 9.
module bcd2binary_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      out_binary
`ifdef BCD2BIN_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   sh_q, sh_d;
  logic [BIN_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]      out_q, out_d;
  logic [3:0]            digit;
  logic [BIN_W-1:0]      acc_step;

`ifdef BCD2BIN_CHECK_EN
  logic                  bad_q, bad_d;
  logic                  err_q, err_d;
`endif

  // acc*10 + digit evaluated 4 bits wider, then wrapped to BIN_W
  assign digit    = sh_q[4*cnt_q +: 4];
  assign acc_step = BIN_W'(({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                           + {{BIN_W{1'b0}}, digit});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
`ifdef BCD2BIN_CHECK_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef BCD2BIN_CHECK_EN
      bad_q   <= bad_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
`ifdef BCD2BIN_CHECK_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = in_bcd;
          acc_d   = '0;
          cnt_d   = CNT_W'(DIGITS - 1);
          state_d = S_CONV;
`ifdef BCD2BIN_CHECK_EN
          bad_d   = 1'b0;
`endif
        end
      end
      S_CONV: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
`ifdef BCD2BIN_CHECK_EN
        bad_d = bad_q | (digit > 4'd9);
`endif
        // Result is loaded on the edge into DONE so it is valid alongside done
        if (cnt_q == '0) begin
          state_d = S_DONE;
          out_d   = acc_step;
`ifdef BCD2BIN_CHECK_EN
          err_d   = bad_q | (digit > 4'd9);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_binary = out_q;
`ifdef BCD2BIN_CHECK_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Randomised self-checking bench for bcd2binary_seq against a positional-sum model.
module tb_bcd2binary_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned BIN_W  = 14;
  localparam int unsigned IW     = 4 * DIGITS;

  logic              clk;
  logic              reset;
  logic              start;
  logic [IW-1:0]     in_bcd;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  out_binary;
`ifdef BCD2BIN_CHECK_EN
  logic              err;
`endif

  int unsigned n_total;
  int unsigned n_bad;
  int unsigned prev_out;

  bcd2binary_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_bcd     (in_bcd),
    .busy       (busy),
    .done       (done),
    .out_binary (out_binary)
`ifdef BCD2BIN_CHECK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sum of digit * 10^position, wrapped to the output width
  function automatic int unsigned ref_value(input logic [IW-1:0] v);
    int unsigned sum;
    int unsigned weight;
    logic [3:0]  d;
    sum    = 0;
    weight = 1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d      = v[4*i +: 4];
      sum    = sum + int'(d) * weight;
      weight = weight * 10;
    end
    return sum % (32'd1 << BIN_W);
  endfunction

  function automatic logic ref_err(input logic [IW-1:0] v);
    logic [3:0] d;
    ref_err = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (d > 4'd9) ref_err = 1'b1;
    end
  endfunction

  // Called at a negedge while idle; in_bcd is scrambled during the conversion.
  task automatic convert(input logic [IW-1:0] bcd);
    int unsigned n;
    logic        got;
    int unsigned exp;
    exp    = ref_value(bcd);
    start  = 1'b1;
    in_bcd = bcd;
    @(posedge clk);
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      start  = 1'b0;
      in_bcd = IW'($urandom);
      if (done) got = 1'b1;
      else begin
        check_eq("busy_conv", 32'(busy), 32'd1);
        check_eq("out_hold", 32'(out_binary), prev_out);
      end
    end
    check_eq("done_seen", 32'(got), 32'd1);
    check_eq("latency", n, DIGITS + 1);
    check_eq("busy_done", 32'(busy), 32'd1);
    check_eq("result", 32'(out_binary), exp);
`ifdef BCD2BIN_CHECK_EN
    check_eq("err", 32'(err), 32'(ref_err(bcd)));
`endif
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("result_held", 32'(out_binary), exp);
    prev_out = exp;
  endtask

  initial begin
    int unsigned ndone;
    int unsigned cyc_a, cyc_b, val_a, val_b;
    logic [IW-1:0] v;

    n_total  = 0;
    n_bad    = 0;
    prev_out = 0;
    reset    = 1'b1;
    start    = 1'b0;
    in_bcd   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_out", 32'(out_binary), 32'd0);
`ifdef BCD2BIN_CHECK_EN
    check_eq("rst_err", 32'(err), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    convert(IW'(16'h1234));
    convert(IW'(16'h9999));
    convert(IW'(16'h0000));
    convert(IW'(16'hFFFF));
    convert(IW'(16'h12A4));
    convert(IW'(16'h0042));

    for (int unsigned t = 0; t < 30; t++) begin
      if (t % 2 == 0) begin
        for (int unsigned i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(9, 0));
      end else begin
        v = IW'($urandom);
      end
      convert(v);
    end

    // start held high: one done per accepted start, back-to-back restart
    start  = 1'b1;
    in_bcd = IW'(16'h1234);
    @(posedge clk);
    ndone = 0; cyc_a = 0; cyc_b = 0; val_a = 0; val_b = 0;
    for (int unsigned c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) in_bcd = IW'(16'h0001);
      if (done) begin
        ndone++;
        if (ndone == 1) begin cyc_a = c; val_a = 32'(out_binary); end
        else begin cyc_b = c; val_b = 32'(out_binary); end
      end
      if (c == 11) start = 1'b0;
    end
    check_eq("hold_ndone", ndone, 32'd2);
    check_eq("hold_cyc_a", cyc_a, DIGITS + 1);
    check_eq("hold_val_a", val_a, 32'd1234);
    check_eq("hold_cyc_b", cyc_b, 2 * DIGITS + 3);
    check_eq("hold_val_b", val_b, 32'd1);
    check_eq("hold_idle", 32'(busy), 32'd0);
    prev_out = 1;

    // reset mid-conversion aborts without a done pulse
    convert(IW'(16'h0777));
    start  = 1'b1;
    in_bcd = IW'(16'h5678);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_out", 32'(out_binary), 32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int unsigned c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("abort_nodone", ndone, 32'd0);
    check_eq("abort_out_hold", 32'(out_binary), 32'd0);
    prev_out = 0;

    convert(IW'(16'h0987));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
